// File: rtl/mem_arb_pkg.sv
// Shared definitions for the N-port memory arbiter.
//   ST_IDLE / ST_GRANT / ST_RELEASE : FSM state encoding
//   ARB_FIXED / ARB_RR              : arbitration policy selectors
//   idx_w()                         : index/counter width helper (minimum 1 bit)
package mem_arb_pkg;

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_GRANT   = 2'd1;
   localparam logic [1:0] ST_RELEASE = 2'd2;

   localparam int ARB_FIXED = 0;
   localparam int ARB_RR    = 1;

   function automatic int idx_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/mem_arb_if.sv
// Requester/controller bus for the N-port memory arbiter.
//   read_request, write_request : per-port requests (held until grant drops)
//   skip_wait, mem_done         : turnaround bypass and controller completion pulse
//   grant, grant_id             : one-hot grant and its index
//   mem_rd, mem_wr              : registered strobes to the SDRAM controller
//   busy, timeout_err, err_port : status outputs
// master = requesters/controller side, slave = arbiter side.
interface mem_arb_if import mem_arb_pkg::*; #(
   parameter int NUM_PORTS = 4
) ();
   localparam int IDW = idx_w(NUM_PORTS);

   logic [NUM_PORTS-1:0] read_request;
   logic [NUM_PORTS-1:0] write_request;
   logic                 skip_wait;
   logic                 mem_done;
   logic [NUM_PORTS-1:0] grant;
   logic [IDW-1:0]       grant_id;
   logic                 mem_rd;
   logic                 mem_wr;
   logic                 busy;
   logic                 timeout_err;
   logic [IDW-1:0]       err_port;

   modport master (
      output read_request, write_request, skip_wait, mem_done,
      input  grant, grant_id, mem_rd, mem_wr, busy, timeout_err, err_port
   );

   modport slave (
      input  read_request, write_request, skip_wait, mem_done,
      output grant, grant_id, mem_rd, mem_wr, busy, timeout_err, err_port
   );
endinterface

// File: rtl/mem_arb_pick.sv
// Combinational winner selection.
//   req_i  : request vector        ptr_i  : round-robin start index
//   mode_i : 0 fixed (highest index wins), 1 round-robin
//   excl_i : ports removed from consideration
//   win_o  : winning index (0 if none)   vld_o : a winner exists
module mem_arb_pick import mem_arb_pkg::*; #(
   parameter int NUM_PORTS = 4,
   localparam int IDW = idx_w(NUM_PORTS)
) (
   input  logic [NUM_PORTS-1:0] req_i,
   input  logic [IDW-1:0]       ptr_i,
   input  logic                 mode_i,
   input  logic [NUM_PORTS-1:0] excl_i,
   output logic [IDW-1:0]       win_o,
   output logic                 vld_o
);
   logic [NUM_PORTS-1:0] cand;
   int                   idx;

   assign cand = req_i & ~excl_i;

   always_comb begin
      win_o = '0;
      vld_o = 1'b0;
      idx   = 0;
      if (mode_i) begin
         // Walk offsets from farthest to nearest so the port closest to the
         // pointer (searching upward with wrap) is the last one written.
         for (int off = NUM_PORTS - 1; off >= 0; off--) begin
            idx = int'(ptr_i) + off;
            if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
            if (cand[idx]) begin
               win_o = IDW'(idx);
               vld_o = 1'b1;
            end
         end
      end else begin
         for (int i = 0; i < NUM_PORTS; i++) begin
            if (cand[i]) begin
               win_o = IDW'(i);
               vld_o = 1'b1;
            end
         end
      end
   end
endmodule

// File: rtl/mem_arbiter_np.sv
// N-port memory arbiter in front of a single-port SDRAM controller.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : mem_arb_if slave (requests, mem_done, skip_wait in;
//              grant, grant_id, mem_rd, mem_wr, busy, timeout_err, err_port out)
// IDLE arbitrates, GRANT holds one port until mem_done/abort/timeout, RELEASE
// gives the controller one cycle with all strobes low (bypassed by skip_wait).
module mem_arbiter_np import mem_arb_pkg::*; #(
   parameter int NUM_PORTS      = 4,
   parameter int ARB_MODE       = 0,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input logic       clk,
   input logic       rst,
   mem_arb_if.slave  bus
);
   localparam int IDW = idx_w(NUM_PORTS);
   localparam int CW  = idx_w(TIMEOUT_CYCLES + 1);

   logic [1:0]           state_q, state_d;
   logic [NUM_PORTS-1:0] grant_q, grant_d;
   logic [IDW-1:0]       gid_q, gid_d;
   logic                 rd_q, rd_d, wr_q, wr_d;
   logic                 tmo_q, tmo_d;
   logic [IDW-1:0]       errp_q, errp_d;
   logic [IDW-1:0]       rr_q, rr_d;
   logic [CW-1:0]        cnt_q, cnt_d;

   logic [NUM_PORTS-1:0] req, excl;
   logic [IDW-1:0]       pick_id;
   logic                 pick_vld;
   logic                 done, abort, expire, release_ev;

   assign req = bus.read_request | bus.write_request;
   // In GRANT the picker serves the skip_wait path and must not re-pick the
   // port being released.
   assign excl = (state_q == ST_GRANT) ? grant_q : '0;

   mem_arb_pick #(.NUM_PORTS(NUM_PORTS)) u_pick (
      .req_i  (req),
      .ptr_i  (rr_q),
      .mode_i (ARB_MODE == ARB_RR),
      .excl_i (excl),
      .win_o  (pick_id),
      .vld_o  (pick_vld)
   );

   assign done       = bus.mem_done;
   assign abort      = ~|(req & grant_q);
   assign expire     = (TIMEOUT_CYCLES != 0) && (cnt_q == CW'(TIMEOUT_CYCLES - 1));
   assign release_ev = done | abort | expire;

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      gid_d   = gid_q;
      rd_d    = rd_q;
      wr_d    = wr_q;
      tmo_d   = 1'b0;
      errp_d  = errp_q;
      rr_d    = rr_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_GRANT: begin
            cnt_d = cnt_q + 1'b1;
            if (release_ev) begin
               grant_d = '0;
               gid_d   = '0;
               rd_d    = 1'b0;
               wr_d    = 1'b0;
               state_d = bus.skip_wait ? ST_IDLE : ST_RELEASE;
               // A coincident completion or abort wins over expiry: no error.
               if (expire && !done && !abort) begin
                  tmo_d  = 1'b1;
                  errp_d = gid_q;
               end
            end
         end
         ST_RELEASE: state_d = ST_IDLE;
         default:    state_d = ST_IDLE;
      endcase
      // New grant from IDLE, or straight out of GRANT on the skip_wait path.
      if ((state_q == ST_IDLE || (state_q == ST_GRANT && release_ev && bus.skip_wait))
          && pick_vld) begin
         state_d          = ST_GRANT;
         grant_d          = '0;
         grant_d[pick_id] = 1'b1;
         gid_d            = pick_id;
         wr_d             = bus.write_request[pick_id];
         rd_d             = ~bus.write_request[pick_id];
         cnt_d            = '0;
         if (ARB_MODE == ARB_RR)
            rr_d = (pick_id == IDW'(NUM_PORTS - 1)) ? '0 : pick_id + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         grant_q <= '0;
         gid_q   <= '0;
         rd_q    <= 1'b0;
         wr_q    <= 1'b0;
         tmo_q   <= 1'b0;
         errp_q  <= '0;
         rr_q    <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         gid_q   <= gid_d;
         rd_q    <= rd_d;
         wr_q    <= wr_d;
         tmo_q   <= tmo_d;
         errp_q  <= errp_d;
         rr_q    <= rr_d;
         cnt_q   <= cnt_d;
      end
   end

   assign bus.grant       = grant_q;
   assign bus.grant_id    = gid_q;
   assign bus.mem_rd      = rd_q;
   assign bus.mem_wr      = wr_q;
   assign bus.busy        = (state_q != ST_IDLE);
   assign bus.timeout_err = tmo_q;
   assign bus.err_port    = errp_q;
endmodule

// File: doc/mem_arbiter_np.md
Name: mem_arbiter_np

Overview:
- Parametrised N-port memory arbiter between cache/DMA requesters and the single-port SDRAM controller host interface.
- Successor to the fixed 4-port priority arbiter.
- Adds selectable fixed-priority or round-robin policy, per-grant read/write qualification, a done-driven release handshake, optional back-to-back grants and a stuck-transaction timeout.

Parameters:
- NUM_PORTS, 4, number of requesters (2..16).
- ARB_MODE, 0, 0 = fixed priority (highest index wins), 1 = round-robin.
- TIMEOUT_CYCLES, 1024, cycles a grant may wait for mem_done before forced release; 0 disables the timeout.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- read_request  in  NUM_PORTS  per-port read request; held by the requester until its grant drops.
- write_request  in  NUM_PORTS  per-port write request; same holding rule.
- skip_wait  in  1  1 = skip the RELEASE turnaround cycle.
- mem_done  in  1  one-cycle pulse from the SDRAM controller: current access complete.
- grant  out  NUM_PORTS  one-hot (or zero), registered.
- grant_id  out  clog2(NUM_PORTS)  index of the granted port; 0 when idle.
- mem_rd  out  1  registered read strobe to the controller.
- mem_wr  out  1  registered write strobe to the controller.
- busy  out  1  high in GRANT and RELEASE states.
- timeout_err  out  1  one-cycle pulse on forced release.
- err_port  out  clog2(NUM_PORTS)  port that timed out; held until the next timeout.

Behaviour:
- Reset (async, on rst high): grant=0, grant_id=0, mem_rd=0, mem_wr=0, busy=0, timeout_err=0, err_port=0, rr pointer=0, hold counter=0, state IDLE.
- States: IDLE, GRANT, RELEASE.
- req[i] = read_request[i] | write_request[i].

IDLE:
- If any req, pick a winner.
- ARB_MODE 0: highest index with req set.
- ARB_MODE 1: first req at or after the rr pointer, searching upward with wrap from NUM_PORTS-1 to 0.
- Next edge: grant[winner]=1, grant_id=winner, state GRANT, hold counter cleared.
- Latency: request sampled at edge k gives grant visible after edge k+1.
- Op select, sampled at grant: write_request wins over read_request on the same port (dirty-line flush before refill). Exactly one of mem_wr/mem_rd is set together with grant.
- ARB_MODE 1: rr pointer = (winner+1) mod NUM_PORTS, updated at the grant edge.

GRANT:
- grant, grant_id and op held constant; the op is not re-evaluated mid-grant.
- Hold counter increments each cycle.
- mem_done=1: grant, mem_rd and mem_wr clear at the next edge. Go to RELEASE, or to IDLE-arbitration if skip_wait=1.
- skip_wait=1 path: arbitration runs in that same cycle on current requests, excluding the port just released, so a new grant can appear at the next edge.
- Both requests of the granted port drop before mem_done (abort): same release path as mem_done.
- Hold counter reaches TIMEOUT_CYCLES (TIMEOUT_CYCLES≠0): forced release, timeout_err=1 for one cycle, err_port=grant_id.
- Priority when simultaneous: mem_done > abort > timeout. Only one release occurs and no error is flagged if mem_done coincides with expiry.

RELEASE:
- One cycle with all grant and strobe outputs 0, so the controller sees RD/WR fall; then IDLE.
- mem_done in IDLE or RELEASE is ignored.

General:
- Requests on ungranted ports never disturb an active grant; no preemption.
- grant is never multi-hot; mem_rd & mem_wr is never 1.
- Reset mid-GRANT drops all outputs immediately (async). The controller is responsible for its own recovery.

Decomposition:
- Package mem_arb_pkg holds:
  - state encoding (IDLE=2'd0, GRANT=2'd1, RELEASE=2'd2);
  - ARB_FIXED=0 and ARB_RR=1;
  - a clog2-based width helper for the grant_id and counter widths.
- One sub-module, mem_arb_pick: combinational winner selection. Inputs: req vector, rr pointer, mode, exclude mask. Outputs: winner index, valid. Shared by both modes and reused by the skip_wait path.

Test Plan:
- Fixed mode, N=4, read_request=4'b0110 held, mem_done 3 cycles after grant: grant=4'b0100 one cycle after the request, mem_rd=1, grant=0 one cycle after done, then grant=4'b0010 after RELEASE.
- Round-robin, all four ports requesting continuously, skip_wait=1, mem_done every 2 cycles: grant sequence 0,1,2,3,0 with no idle cycle between grants.
- Port 2 with read and write asserted together: mem_wr=1, mem_rd=0 for the whole grant; write_request dropped mid-grant with read still high: op unchanged until mem_done.
- TIMEOUT_CYCLES=8, port 1 granted, no mem_done: grant drops after 8 cycles, timeout_err pulses once, err_port=1; a coincident mem_done on cycle 8 gives no error.
- rst asserted mid-GRANT between clock edges: grant, mem_rd and mem_wr go to 0 immediately; after release, the first round-robin grant goes to the lowest requesting port ≥0.
- Granted port drops its request before done: abort release, RELEASE cycle observed, no timeout_err; a mem_done arriving later in IDLE is ignored.
